// File: rtl/wb_pkg.sv
// Shared widths, select/enable encodings and the result entry type for the writeback controller.
package wb_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic SEL_ALU   = 1'b0;
    localparam logic SEL_MDR   = 1'b1;
    localparam logic WE_ASSERT = 1'b0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_ctrl_if.sv
// Result handshakes, register-file write port and scoreboard query signals of wb_ctrl.
interface wb_ctrl_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_rd;
    logic [XLEN-1:0]   ld_data;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_alu_data;
    logic [XLEN-1:0]   wb_mdr_data;
    logic              wb_sel;
    logic              wb_we_n;
    logic              iss_valid;
    logic [REG_AW-1:0] iss_rd;
    logic [REG_AW-1:0] q_rs1;
    logic [REG_AW-1:0] q_rs2;
    logic              haz_rs1;
    logic              haz_rs2;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               iss_valid, iss_rd, q_rs1, q_rs2,
        output alu_ready, ld_ready, wb_rd, wb_alu_data, wb_mdr_data,
               wb_sel, wb_we_n, haz_rs1, haz_rs2
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               iss_valid, iss_rd, q_rs1, q_rs2,
        input  alu_ready, ld_ready, wb_rd, wb_alu_data, wb_mdr_data,
               wb_sel, wb_we_n, haz_rs1, haz_rs2
    );
endinterface

// File: rtl/wb_skid_buf.sv
// One-entry {rd, data} holding register: load captures an entry, drain releases it.
module wb_skid_buf
    import wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  logic      drain,
    input  wb_entry_t in_entry,
    output logic      valid,
    output wb_entry_t out_entry
);
    logic      valid_reg;
    wb_entry_t entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            entry_reg <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            entry_reg <= in_entry;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid     = valid_reg;
    assign out_entry = entry_reg;
endmodule

// File: rtl/wb_ctrl.sv
// Writeback arbiter: skid > load > ALU, registered register-file write port.
// Optional pending-destination scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_ctrl
    import wb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    wb_ctrl_if.slave bus
);
    logic              skid_valid;
    wb_entry_t         skid_entry;
    logic              skid_load;
    logic              skid_drain;
    logic              alu_fire;
    logic              ld_fire;
    logic              issue;
    logic              issue_sel;
    logic [REG_AW-1:0] issue_rd;
    logic [XLEN-1:0]   issue_data;

    logic [REG_AW-1:0] wb_rd_reg;
    logic [XLEN-1:0]   wb_alu_data_reg;
    logic [XLEN-1:0]   wb_mdr_data_reg;
    logic              wb_sel_reg;
    logic              wb_we_n_reg;

    wb_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .drain     (skid_drain),
        .in_entry  ({bus.alu_rd, bus.alu_data}),
        .valid     (skid_valid),
        .out_entry (skid_entry)
    );

    // Readiness depends only on the skid state, never on the valid inputs.
    assign bus.alu_ready = !skid_valid;
    assign bus.ld_ready  = !skid_valid;
    assign alu_fire      = bus.alu_valid && !skid_valid;
    assign ld_fire       = bus.ld_valid && !skid_valid;

    always_comb begin
        issue      = 1'b0;
        issue_sel  = SEL_ALU;
        issue_rd   = '0;
        issue_data = '0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        if (skid_valid) begin
            issue      = 1'b1;
            issue_rd   = skid_entry.rd;
            issue_data = skid_entry.data;
            skid_drain = 1'b1;
        end else if (ld_fire) begin
            issue      = 1'b1;
            issue_sel  = SEL_MDR;
            issue_rd   = bus.ld_rd;
            issue_data = bus.ld_data;
            skid_load  = alu_fire;
        end else if (alu_fire) begin
            issue      = 1'b1;
            issue_rd   = bus.alu_rd;
            issue_data = bus.alu_data;
        end
    end

    // Writes to x0 still consume the slot but keep the enable deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd_reg       <= '0;
            wb_alu_data_reg <= '0;
            wb_mdr_data_reg <= '0;
            wb_sel_reg      <= SEL_ALU;
            wb_we_n_reg     <= !WE_ASSERT;
        end else if (issue) begin
            wb_rd_reg   <= issue_rd;
            wb_sel_reg  <= issue_sel;
            wb_we_n_reg <= (issue_rd == '0) ? !WE_ASSERT : WE_ASSERT;
            if (issue_sel == SEL_MDR) begin
                wb_mdr_data_reg <= issue_data;
            end else begin
                wb_alu_data_reg <= issue_data;
            end
        end else begin
            wb_we_n_reg <= !WE_ASSERT;
        end
    end

    assign bus.wb_rd       = wb_rd_reg;
    assign bus.wb_alu_data = wb_alu_data_reg;
    assign bus.wb_mdr_data = wb_mdr_data_reg;
    assign bus.wb_sel      = wb_sel_reg;
    assign bus.wb_we_n     = wb_we_n_reg;

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pending_reg;
    logic [NUM_REGS-1:0] pending_next;
    logic                write_clear;

    assign write_clear     = issue && (issue_rd != '0);
    assign pending_next[0] = 1'b0;

    // Set takes precedence over a same-edge clear of the same register.
    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_pend
            assign pending_next[gi] =
                (bus.iss_valid && bus.iss_rd == REG_AW'(gi)) ? 1'b1 :
                (write_clear && issue_rd == REG_AW'(gi))     ? 1'b0 :
                pending_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign bus.haz_rs1 = pending_reg[bus.q_rs1];
    assign bus.haz_rs2 = pending_reg[bus.q_rs2];
`else
    logic unused_sb;
    assign unused_sb   = ^{bus.iss_valid, bus.iss_rd, bus.q_rs1, bus.q_rs2};
    assign bus.haz_rs1 = 1'b0;
    assign bus.haz_rs2 = 1'b0;
`endif
endmodule

// File: tb/tb_wb_ctrl.sv
// Directed + randomized bench for wb_ctrl against a queue-based writeback model.
// Scoreboard expectations follow the WB_SCOREBOARD_EN macro.
module tb_wb_ctrl;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_step = 0;

    wb_ctrl_if bus ();

    wb_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: held ALU results waiting for a slot, current port values, pending set.
    logic [36:0] m_held[$];
    logic [4:0]  m_rd;
    logic [31:0] m_alu;
    logic [31:0] m_mdr;
    logic        m_sel;
    logic        m_we_n;
    logic        m_pend[32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held.delete();
        m_rd   = '0;
        m_alu  = '0;
        m_mdr  = '0;
        m_sel  = 1'b0;
        m_we_n = 1'b1;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_rd  = 0; bus.ld_data  = 0;
        bus.iss_valid = 0; bus.iss_rd = 0; bus.q_rs1 = 0; bus.q_rs2 = 0;
    endtask

    function automatic logic exp_haz(input logic [4:0] q);
`ifdef WB_SCOREBOARD_EN
        return (q == 0) ? 1'b0 : m_pend[q];
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: drive at negedge, check readies, advance model, check outputs after posedge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] q1, input logic [4:0] q2);
        logic        issue;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        sel;
        @(negedge clk);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
        bus.ld_valid  = lv; bus.ld_rd  = lrd; bus.ld_data  = ldd;
        bus.iss_valid = iv; bus.iss_rd = ird; bus.q_rs1 = q1; bus.q_rs2 = q2;
        #1;
        chk("alu_ready", 32'(bus.alu_ready), 32'(m_held.size() == 0));
        chk("ld_ready",  32'(bus.ld_ready),  32'(m_held.size() == 0));

        issue = 1'b0; rd = '0; data = '0; sel = 1'b0;
        if (m_held.size() != 0) begin
            {rd, data} = m_held.pop_front();
            issue = 1'b1;
        end else if (lv) begin
            issue = 1'b1; rd = lrd; data = ldd; sel = 1'b1;
            if (av) m_held.push_back({ard, ad});
        end else if (av) begin
            issue = 1'b1; rd = ard; data = ad;
        end
        if (issue) begin
            m_rd = rd; m_sel = sel; m_we_n = (rd == 0);
            if (sel) m_mdr = data; else m_alu = data;
            if (rd != 0) m_pend[rd] = 1'b0;
        end else begin
            m_we_n = 1'b1;
        end
        if (iv && ird != 0) m_pend[ird] = 1'b1;

        @(posedge clk);
        #1;
        n_step++;
        $display("step %0d: alu v=%0d rd=%0d | ld v=%0d rd=%0d | iss v=%0d rd=%0d -> we_n=%0d rd=%0d sel=%0d",
                 n_step, av, ard, lv, lrd, iv, ird, bus.wb_we_n, bus.wb_rd, bus.wb_sel);
        chk("wb_we_n",     32'(bus.wb_we_n), 32'(m_we_n));
        chk("wb_rd",       32'(bus.wb_rd),   32'(m_rd));
        chk("wb_sel",      32'(bus.wb_sel),  32'(m_sel));
        chk("wb_alu_data", bus.wb_alu_data,  m_alu);
        chk("wb_mdr_data", bus.wb_mdr_data,  m_mdr);
        chk("haz_rs1",     32'(bus.haz_rs1), 32'(exp_haz(q1)));
        chk("haz_rs2",     32'(bus.haz_rs2), 32'(exp_haz(q2)));
    endtask

    task automatic idle(input logic [4:0] q1);
        step(0, 0, 0, 0, 0, 0, 0, 0, q1, 0);
    endtask

    // Asynchronous reset in the middle of a cycle, released at a negedge.
    task automatic mid_reset();
        @(negedge clk);
        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_we_n",      32'(bus.wb_we_n),   32'd1);
        chk("rst_rd",        32'(bus.wb_rd),     32'd0);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst_ld_ready",  32'(bus.ld_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we_n",     32'(bus.wb_we_n),   32'd1);
        chk("reset_rd",       32'(bus.wb_rd),     32'd0);
        chk("reset_sel",      32'(bus.wb_sel),    32'd0);
        chk("reset_alu_data", bus.wb_alu_data,    32'd0);
        chk("reset_mdr_data", bus.wb_mdr_data,    32'd0);
        chk("reset_alu_rdy",  32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU only
        step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        // Collision: load first, ALU from skid next cycle
        step(1, 4, 32'hBBBB, 1, 3, 32'hAAAA, 0, 0, 0, 0);
        step(1, 9, 32'hDEAD, 1, 10, 32'hBEEF, 0, 0, 0, 0);
        idle(0);
        // Load to x0 is accepted and dropped
        step(0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 0);
        idle(0);
        // Reset while the skid holds an ALU result
        step(1, 6, 32'h6666, 1, 8, 32'h8888, 0, 0, 0, 0);
        mid_reset();
        idle(0);
        idle(0);
        // Scoreboard: mark, write clears, same-edge set wins
        step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(7);
        step(1, 7, 32'h7777, 0, 0, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        step(1, 7, 32'h7070, 0, 0, 0, 1, 7, 7, 7);
        idle(7);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom),
                 5'($urandom), 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
